// File: rtl/csr_file_ex_pkg.sv
// Shared definitions for the EX-stage machine-mode CSR file:
// CSR addresses, CSR ALU operation encodings, mstatus field masks
// and the read-only address range test.
package csr_file_ex_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MSTATUS_MIE  = 32'h0000_0008;
  localparam logic [31:0] MSTATUS_MPIE = 32'h0000_0080;
  localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;

  // Takes only addr[11:10]; addresses with both bits set are read-only.
  function automatic logic csr_is_ro(input logic [1:0] addr_top);
    return addr_top == 2'b11;
  endfunction

endpackage

// File: rtl/csr_file_ex_counter64.sv
// csr_counter64: 64-bit free-running counter with software-writable halves.
// Ports: clk, rst_n (async active-low), inc_en (count this cycle),
//        wr_lo / wr_hi (load wdata into the low / high half),
//        wdata (32-bit load value), count (current 64-bit value).
// A write to either half takes priority over the increment; the other
// half holds its value.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (wr_lo) begin
      cnt_q <= {cnt_q[63:32], wdata};
    end else if (wr_hi) begin
      cnt_q <= {wdata, cnt_q[31:0]};
    end else if (inc_en) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/csr_file_ex.sv
// csr_file_ex: machine-mode CSR register file and CSR ALU in the EX stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bubbleE               EX held: no CSR write, no retire counting
//   CSR_addr_EX           CSR address
//   CSR_zimm_EX           zero-extended immediate operand
//   CSR_zimm_or_reg_EX    1 = zimm operand, 0 = reg1_EX operand
//   CSR_write_en_EX       instruction is a CSR instruction
//   CSR_op_EX             00 none, 01 RW, 10 RS, 11 RC
//   reg1_EX               forwarded rs1 value
//   instr_retire          one instruction retires this cycle
//   CSR_rdata_EX          pre-write CSR value (combinational)
//   CSR_illegal_EX        illegal CSR access (combinational)
//   mtvec_out, mepc_out   current mtvec / mepc for fetch redirect
module csr_file_ex
  import csr_file_ex_pkg::*;
#(
  parameter logic [31:0] MVENDORID = 32'h0,
  parameter logic [31:0] MARCHID   = 32'h0,
  parameter logic [31:0] MIMPID    = 32'h1,
  parameter logic [31:0] HARTID    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubbleE,
  input  logic [11:0] CSR_addr_EX,
  input  logic [31:0] CSR_zimm_EX,
  input  logic        CSR_zimm_or_reg_EX,
  input  logic        CSR_write_en_EX,
  input  logic [1:0]  CSR_op_EX,
  input  logic [31:0] reg1_EX,
  input  logic        instr_retire,
  output logic [31:0] CSR_rdata_EX,
  output logic        CSR_illegal_EX,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out
);

  csr_op_e     op;
  logic [31:0] src;
  logic [31:0] rdata;
  logic        implemented;
  logic [31:0] wval;
  logic        active;
  logic        wr_req;
  logic        commit;

  // Only the writable bits are stored; fixed-zero bits are rebuilt on read.
  logic        mie_q;
  logic        mpie_q;
  logic [31:2] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:2] mepc_q;
  logic [31:0] mcause_q;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  assign op  = csr_op_e'(CSR_op_EX);
  assign src = CSR_zimm_or_reg_EX ? CSR_zimm_EX : reg1_EX;

  always_comb begin
    rdata       = '0;
    implemented = 1'b1;
    case (CSR_addr_EX)
      CSR_MSTATUS:   rdata = MSTATUS_MPP | (mie_q ? MSTATUS_MIE : '0)
                             | (mpie_q ? MSTATUS_MPIE : '0);
      CSR_MTVEC:     rdata = {mtvec_q, 2'b00};
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = {mepc_q, 2'b00};
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MCYCLE,
      CSR_CYCLE:     rdata = mcycle[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:    rdata = mcycle[63:32];
      CSR_MINSTRET,
      CSR_INSTRET:   rdata = minstret[31:0];
      CSR_MINSTRETH,
      CSR_INSTRETH:  rdata = minstret[63:32];
      CSR_MVENDORID: rdata = MVENDORID;
      CSR_MARCHID:   rdata = MARCHID;
      CSR_MIMPID:    rdata = MIMPID;
      CSR_MHARTID:   rdata = HARTID;
      default:       implemented = 1'b0;
    endcase
  end

  always_comb begin
    wval = '0;
    case (op)
      CSR_OP_RW: wval = src;
      CSR_OP_RS: wval = rdata | src;
      CSR_OP_RC: wval = rdata & ~src;
      default:   wval = rdata;
    endcase
  end

  // Set/clear with a zero operand is a pure read and never counts as a write.
  assign active         = CSR_write_en_EX && (op != CSR_OP_NONE);
  assign wr_req         = active && !(((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (src == '0));
  assign CSR_illegal_EX = active && (!implemented || (csr_is_ro(CSR_addr_EX[11:10]) && wr_req));
  assign commit         = wr_req && !bubbleE && !CSR_illegal_EX;
  assign CSR_rdata_EX   = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (commit) begin
      case (CSR_addr_EX)
        CSR_MSTATUS: begin
          mie_q  <= wval[3];
          mpie_q <= wval[7];
        end
        CSR_MTVEC:    mtvec_q    <= wval[31:2];
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MEPC:     mepc_q     <= wval[31:2];
        CSR_MCAUSE:   mcause_q   <= wval;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (1'b1),
    .wr_lo  (commit && (CSR_addr_EX == CSR_MCYCLE)),
    .wr_hi  (commit && (CSR_addr_EX == CSR_MCYCLEH)),
    .wdata  (wval),
    .count  (mcycle)
  );

  csr_counter64 u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (instr_retire && !bubbleE),
    .wr_lo  (commit && (CSR_addr_EX == CSR_MINSTRET)),
    .wr_hi  (commit && (CSR_addr_EX == CSR_MINSTRETH)),
    .wdata  (wval),
    .count  (minstret)
  );

  assign mtvec_out = {mtvec_q, 2'b00};
  assign mepc_out  = {mepc_q, 2'b00};

endmodule

// File: doc/csr_file_ex.md
Name: csr_file_ex

Overview:
- Machine-mode CSR register file and CSR ALU in the EX stage, directly downstream of the ID/EX CSR pipeline register.
- Consumes the registered CSR address, zimm, zimm/reg select and write-enable, plus the forwarded rs1 value.
- Returns the old CSR value for write-back. Performs CSRRW/CSRRS/CSRRC read-modify-write at the clock edge.
- Maintains the mcycle/minstret 64-bit counters and exports mtvec/mepc to the fetch-redirect logic.

Parameters:
- MVENDORID, 32'h0, value returned by 0xF11.
- MARCHID, 32'h0, value returned by 0xF12.
- MIMPID, 32'h1, value returned by 0xF13.
- HARTID, 32'h0, value returned by 0xF14.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- bubbleE  in  1  EX stage held; suppresses CSR writes and retire counting this cycle.
- CSR_addr_EX  in  12  CSR address.
- CSR_zimm_EX  in  32  zero-extended 5-bit immediate.
- CSR_zimm_or_reg_EX  in  1  1 = operand is zimm, 0 = operand is reg1_EX.
- CSR_write_en_EX  in  1  instruction is a CSR instruction.
- CSR_op_EX  in  2  00 none, 01 RW, 10 RS, 11 RC.
- reg1_EX  in  32  forwarded rs1 value.
- instr_retire  in  1  one instruction retires this cycle.
- CSR_rdata_EX  out  32  old CSR value, combinational.
- CSR_illegal_EX  out  1  illegal CSR access, combinational.
- mtvec_out  out  32  current mtvec.
- mepc_out  out  32  current mepc.

Behaviour:
- Operand selection: src = CSR_zimm_or_reg_EX ? CSR_zimm_EX : reg1_EX.
- Write attempt: wr_req = CSR_write_en_EX && op != 00 && !(op in {RS,RC} && src == 0).
- New value: RW gives src; RS gives old | src; RC gives old & ~src.
- Read path is combinational from the current state. CSR_rdata_EX shows the pre-write value in the same cycle; the write becomes visible the following cycle.
- Commit rule: the write happens at posedge only when wr_req && !bubbleE && !CSR_illegal_EX. A held (bubbled) instruction writes exactly once, on the cycle bubbleE is low.
- Implemented CSRs (unlisted addresses read 0):
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mtvec 0x305: bits[1:0] read 0 (direct mode only).
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: full 32 bits.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82: read-only aliases of the counters.
  - 0xF11-0xF14: read-only, return the parameter values.
- CSR_illegal_EX = CSR_write_en_EX && op != 00 && (address not implemented || (addr[11:10]==2'b11 && wr_req)).
  - An illegal access produces no write.
  - CSR_rdata_EX still returns the read value (0 if the address is unimplemented).
- Counters:
  - mcycle increments by 1 every cycle, with 64-bit wrap.
  - minstret increments when instr_retire && !bubbleE.
  - A committed software write to either half wins over the increment for that whole counter in that cycle: the written half takes the new value and the other half holds.
  - Carry from bit 31 into bit 32 is a full 64-bit add; 0xFFFFFFFF_FFFFFFFF wraps to 0.
- Reset: assertion clears every register to 0 immediately, including both counters; a CSR write in flight is lost. mstatus reads 0x00001800 after reset. CSR_rdata_EX and CSR_illegal_EX follow their inputs combinationally.
- Simultaneous events: a write and a read of the same CSR in the same cycle return the old value. A write in cycle N is seen by a read in cycle N+1; no internal bypass.

Decomposition:
- Shared package:
  - CSR address constants.
  - CSR_OP_NONE/RW/RS/RC encodings.
  - mstatus field masks (MIE, MPIE, MPP).
  - the read-only range test (addr[11:10]==2'b11).
- Sub-module csr_counter64: 64-bit counter with an increment enable, lo/hi write enables and a 32-bit write data port, instantiated twice (mcycle, minstret).

Test Plan:
- Reset: rst_n low mid-run, then read 0x300/0xB00 -> rdata 0x00001800, then 0x00000000; after one clk mcycle reads 1.
- CSRRW 0x340, reg1=0xDEADBEEF -> rdata 0 that cycle; next-cycle read gives 0xDEADBEEF. CSRRC zimm=0x0F -> then reads 0xDEADBEE0.
- mtvec write 0x80000103 -> reads 0x80000100 and mtvec_out=0x80000100. mstatus write 0xFFFFFFFF -> reads 0x00001888.
- Read-only and illegal: CSRRS 0xC00 with zimm=0 -> legal, returns cycle. CSRRW 0xC00 -> illegal=1, no state change. Address 0x7C0 -> illegal=1, rdata 0.
- Counter edges:
  - minstret written to 0xFFFFFFFF, then one retire -> minstret=0, minstreth=1.
  - write mcycle=5 -> next read 5, following cycle 6.
- bubbleE=1 for 3 cycles with CSRRS 0x340 src=0x1 -> no write during the hold; written exactly once after release. minstret does not count retires while bubbleE=1.
